// File: rtl/mult_integrated_disp_pkg.sv
// ----------------------------------------------------------------------------
// mult_integrated_disp_pkg
// Shared widths, BCD digit type and 7-segment lamp patterns for the
// multiplier display block.
// Segment patterns are active-high (1 = lit), bit order {g,f,e,d,c,b,a}.
// ----------------------------------------------------------------------------
package mult_integrated_disp_pkg;

    localparam int OPERAND_W = 4;
    localparam int PRODUCT_W = 8;
    localparam int SEG_W     = 7;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/mult_integrated_disp_seg7_decoder.sv
// ----------------------------------------------------------------------------
// seg7_decoder
// Combinational BCD digit to 7-segment lamp pattern.
// Ports:
//   digit : BCD input (0..9 meaningful; 10..15 decode to blank)
//   seg   : lamp pattern, active-high, {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module seg7_decoder
    import mult_integrated_disp_pkg::*;
(
    input  bcd_digit_t       digit,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mult_integrated_disp.sv
// ----------------------------------------------------------------------------
// mult_integrated_disp
// Unsigned 4x4 multiplier driving a 3-digit 7-segment display.
//   stage 1 : register a, b
//   comb    : shift-add partial-product multiply -> 8-bit product,
//             double-dabble -> hundreds/tens/ones BCD, 7-seg decode
//   stage 2 : register the three lamp patterns
// Latency 2 clocks, one operand pair accepted per clock, no handshake.
// Ports:
//   clk, rst (asynchronous, active-high)
//   a, b                : 4-bit unsigned operands
//   ones_lamp, tens_lamp, hundreds_lamp : 7-bit lamp patterns {g..a}
// Build option:
//   LEADING_ZERO_BLANK_EN - blank leading-zero hundreds/tens digits
//                           (ones digit is never blanked).
// ----------------------------------------------------------------------------
module mult_integrated_disp
    import mult_integrated_disp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic [SEG_W-1:0]     ones_lamp,
    output logic [SEG_W-1:0]     tens_lamp,
    output logic [SEG_W-1:0]     hundreds_lamp
);

    // BCD working width: three digits on top of the binary product.
    localparam int DD_W = 12 + PRODUCT_W;

    logic [OPERAND_W-1:0] a_reg;
    logic [OPERAND_W-1:0] b_reg;

    logic [PRODUCT_W-1:0] pp [OPERAND_W];
    logic [PRODUCT_W-1:0] product;

    logic [DD_W-1:0] dd_work;
    bcd_digit_t      ones_digit;
    bcd_digit_t      tens_digit;
    bcd_digit_t      hundreds_digit;

    logic [SEG_W-1:0] ones_seg;
    logic [SEG_W-1:0] tens_seg;
    logic [SEG_W-1:0] hundreds_seg;
    logic [SEG_W-1:0] ones_next;
    logic [SEG_W-1:0] tens_next;
    logic [SEG_W-1:0] hundreds_next;

    // ---------------- stage 1: operand registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            a_reg <= a;
            b_reg <= b;
        end
    end

    // ---------------- shift-add multiplier ----------------
    // Row gi is the multiplicand shifted gi places, gated by multiplier bit gi.
    generate
        for (genvar gi = 0; gi < OPERAND_W; gi++) begin : g_pp
            assign pp[gi] = b_reg[gi]
                          ? ({{(PRODUCT_W-OPERAND_W){1'b0}}, a_reg} << gi)
                          : '0;
        end
    endgenerate

    // 15*15 = 225 fits in 8 bits, so the plain sum never overflows.
    assign product = pp[0] + pp[1] + pp[2] + pp[3];

    // ---------------- double-dabble binary to BCD ----------------
    // Before each left shift any BCD digit >= 5 gets +3 so that the shift
    // carries into the next decade correctly.
    always_comb begin
        dd_work = {{(DD_W-PRODUCT_W){1'b0}}, product};
        for (int i = 0; i < PRODUCT_W; i++) begin
            if (dd_work[PRODUCT_W+3:PRODUCT_W] >= 4'd5)
                dd_work[PRODUCT_W+3:PRODUCT_W] = dd_work[PRODUCT_W+3:PRODUCT_W] + 4'd3;
            if (dd_work[PRODUCT_W+7:PRODUCT_W+4] >= 4'd5)
                dd_work[PRODUCT_W+7:PRODUCT_W+4] = dd_work[PRODUCT_W+7:PRODUCT_W+4] + 4'd3;
            if (dd_work[PRODUCT_W+11:PRODUCT_W+8] >= 4'd5)
                dd_work[PRODUCT_W+11:PRODUCT_W+8] = dd_work[PRODUCT_W+11:PRODUCT_W+8] + 4'd3;
            dd_work = dd_work << 1;
        end
    end

    assign ones_digit     = dd_work[PRODUCT_W+3:PRODUCT_W];
    assign tens_digit     = dd_work[PRODUCT_W+7:PRODUCT_W+4];
    assign hundreds_digit = dd_work[PRODUCT_W+11:PRODUCT_W+8];

    // ---------------- 7-segment decode ----------------
    seg7_decoder u_dec_ones     (.digit(ones_digit),     .seg(ones_seg));
    seg7_decoder u_dec_tens     (.digit(tens_digit),     .seg(tens_seg));
    seg7_decoder u_dec_hundreds (.digit(hundreds_digit), .seg(hundreds_seg));

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [SEG_W-1:0] HUNDREDS_RST = SEG_BLANK;
    localparam logic [SEG_W-1:0] TENS_RST     = SEG_BLANK;

    // Tens is only a leading zero when hundreds is also zero (e.g. 105 keeps it).
    assign hundreds_next = (hundreds_digit == 4'd0) ? SEG_BLANK : hundreds_seg;
    assign tens_next     = ((hundreds_digit == 4'd0) && (tens_digit == 4'd0))
                         ? SEG_BLANK : tens_seg;
`else
    localparam logic [SEG_W-1:0] HUNDREDS_RST = SEG_0;
    localparam logic [SEG_W-1:0] TENS_RST     = SEG_0;

    assign hundreds_next = hundreds_seg;
    assign tens_next     = tens_seg;
`endif
    assign ones_next = ones_seg;

    // ---------------- stage 2: lamp registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hundreds_lamp <= HUNDREDS_RST;
            tens_lamp     <= TENS_RST;
            ones_lamp     <= SEG_0;
        end else begin
            hundreds_lamp <= hundreds_next;
            tens_lamp     <= tens_next;
            ones_lamp     <= ones_next;
        end
    end

endmodule

// File: tb/tb_mult_integrated_disp.sv
// ----------------------------------------------------------------------------
// tb_mult_integrated_disp
// Scoreboard bench: the driver pushes the expected lamp triple for each
// operand pair; a monitor pops and compares when the pair reaches the lamps.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_integrated_disp;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [6:0] ones_lamp;
    logic [6:0] tens_lamp;
    logic [6:0] hundreds_lamp;

    typedef struct {
        int         prod;
        logic [6:0] h;
        logic [6:0] t;
        logic [6:0] o;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;
    logic issued = 1'b0;
    logic vld_d1 = 1'b0;
    logic vld_d2 = 1'b0;

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111};

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] RST_H = 7'b0000000;
    localparam logic [6:0] RST_T = 7'b0000000;
`else
    localparam logic [6:0] RST_H = 7'b0111111;
    localparam logic [6:0] RST_T = 7'b0111111;
`endif
    localparam logic [6:0] RST_O = 7'b0111111;

    mult_integrated_disp dut (
        .clk           (clk),
        .rst           (rst),
        .a             (a),
        .b             (b),
        .ones_lamp     (ones_lamp),
        .tens_lamp     (tens_lamp),
        .hundreds_lamp (hundreds_lamp)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits of the arithmetic product, looked up in a table.
    function automatic exp_t model(input int x, input int y);
        exp_t e;
        int   p, hd, td, od;
        p  = x * y;
        hd = p / 100;
        td = (p / 10) % 10;
        od = p % 10;
        e.prod = p;
        e.h = seg_tab[hd];
        e.t = seg_tab[td];
        e.o = seg_tab[od];
`ifdef LEADING_ZERO_BLANK_EN
        if (hd == 0) e.h = 7'b0000000;
        if (hd == 0 && td == 0) e.t = 7'b0000000;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input int x, input int y);
        @(negedge clk);
        a = 4'(x);
        b = 4'(y);
        issued = 1'b1;
        exp_q.push_back(model(x, y));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            issued = 1'b0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hundreds"}, hundreds_lamp, RST_H);
        chk({tag, "_tens"},     tens_lamp,     RST_T);
        chk({tag, "_ones"},     ones_lamp,     RST_O);
    endtask

    // Pipeline occupancy tracker: a pair issued before edge k is on the lamps after edge k+1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_d1 <= 1'b0;
            vld_d2 <= 1'b0;
        end else begin
            vld_d1 <= issued;
            vld_d2 <= vld_d1;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst && vld_d2) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow: got output with empty queue at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d product=%0d lamps h=%b t=%b o=%b", n_txn, e.prod,
                         hundreds_lamp, tens_lamp, ones_lamp);
                chk("hundreds", hundreds_lamp, e.h);
                chk("tens",     tens_lamp,     e.t);
                chk("ones",     ones_lamp,     e.o);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a   = 4'd0;
        b   = 4'd0;
        #3;
        chk_reset("rst_before_clk");
        repeat (2) @(negedge clk);
        chk_reset("rst_held");
        rst = 1'b0;

        // Directed pairs, issued back to back
        drive(0, 0);
        drive(15, 15);
        drive(9, 11);
        drive(12, 10);
        drive(3, 4);
        drive(7, 8);
        drive(5, 5);
        idle(3);

        // Asynchronous reset while 225 is in flight
        drive(15, 15);
        @(posedge clk);
        #2;
        rst    = 1'b1;
        issued = 1'b0;
        a      = 4'd0;
        b      = 4'd0;
        exp_q.delete();
        #1;
        chk_reset("async_rst_immediate");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset("async_rst_no_225");
        end
        rst = 1'b0;

        // Random pairs with occasional bubbles
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) idle(1);
        end

        // Exhaustive sweep
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                drive(x, y);
        idle(4);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d outputs outstanding, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
